// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback block.
// WB_DATA_W is the result width the FIFO entry type is built for.
package wb_pkg;

    localparam int REG_ADRS_W = 5;
    localparam int N_REGS     = 32;
    localparam int WB_DATA_W  = 32;

    typedef struct packed {
        logic                  kill;
        logic [REG_ADRS_W-1:0] adrs;
        logic [WB_DATA_W-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO: entry storage, head/tail pointers, occupancy and per-entry kill marking.
// With WB_HAZARD_EN defined it also provides the decode-stage hazard compare (chk_adrs/chk_hit).
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = WB_DATA_W,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [REG_ADRS_W-1:0] push_adrs,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [REG_ADRS_W-1:0] kill_adrs,
    output wb_entry_t             head,
`ifdef WB_HAZARD_EN
    input  logic [REG_ADRS_W-1:0] chk_adrs,
    output logic                  chk_hit,
`endif
    output logic [CNT_W-1:0]      count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_fifo: DEPTH must be a power of two and at least 2");
    end
    if (DATA_W != WB_DATA_W) begin : g_bad_width
        $error("wb_fifo: DATA_W must match wb_pkg::WB_DATA_W");
    end

    wb_entry_t          mem [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                wr_ptr         <= wr_ptr + PTR_W'(1);
                valid[wr_ptr]  <= 1'b1;
            end
            if (pop) begin
                rd_ptr         <= rd_ptr + PTR_W'(1);
                valid[rd_ptr]  <= 1'b0;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage. The push write comes last so a load entering on the
    // same edge as a matching ALU write is treated as younger and stays live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && valid[i] && mem[i].adrs == kill_adrs) begin
                mem[i].kill <= 1'b1;
            end
        end
        if (push) begin
            mem[wr_ptr] <= '{kill: 1'b0, adrs: push_adrs, data: push_data};
        end
    end

    assign head = mem[rd_ptr];

`ifdef WB_HAZARD_EN
    logic hit;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && !mem[i].kill && mem[i].adrs == chk_adrs) begin
                hit = 1'b1;
            end
        end
    end

    // Register 0 is never a real dependency.
    assign chk_hit = hit && (chk_adrs != '0);
`endif

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port arbiter: unbuffered ALU results win, buffered loads drain on idle cycles.
// Optional WB_HAZARD_EN macro adds the chk_adrs/chk_hit decode hazard compare.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = WB_DATA_W,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk_cpu,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  alu_valid,
    input  logic [REG_ADRS_W-1:0] alu_adrs,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADRS_W-1:0] ld_adrs,
    input  logic [DATA_W-1:0]     ld_data,
    output logic                  wr_en,
    output logic [REG_ADRS_W-1:0] wr_adrs,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  pending,
`ifdef WB_HAZARD_EN
    input  logic [REG_ADRS_W-1:0] chk_adrs,
    output logic                  chk_hit,
`endif
    output logic [CNT_W-1:0]      count
);

    logic      alu_wr;
    logic      push;
    logic      pop;
    wb_entry_t head;

    // Writes to r0 are architectural no-ops, so they neither use the port nor kill loads.
    assign alu_wr   = alu_valid && (alu_adrs != '0);
    assign ld_ready = count < CNT_W'(DEPTH);
    assign pending  = count != '0;
    assign push     = ld_valid && ld_ready && (ld_adrs != '0) && !flush;
    assign pop      = !alu_wr && pending && !flush;

    wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk_cpu),
        .rst_n     (reset_n),
        .flush     (flush),
        .push      (push),
        .push_adrs (ld_adrs),
        .push_data (ld_data),
        .pop       (pop),
        .kill_en   (alu_wr),
        .kill_adrs (alu_adrs),
        .head      (head),
`ifdef WB_HAZARD_EN
        .chk_adrs  (chk_adrs),
        .chk_hit   (chk_hit),
`endif
        .count     (count)
    );

    // Write-port register stage; a killed head is consumed without writing.
    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            wr_en   <= 1'b0;
            wr_adrs <= '0;
            wr_data <= '0;
        end else if (alu_wr) begin
            wr_en   <= 1'b1;
            wr_adrs <= alu_adrs;
            wr_data <= alu_data;
        end else if (pop) begin
            wr_en   <= !head.kill;
            wr_adrs <= head.adrs;
            wr_data <= head.data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

endmodule
